// File: rtl/osbm_arb.sv
// Per-output round-robin arbiter for the 4-way switch: one-cycle ack to the winning input,
// crossbar select held until that input's tail flit passes, optional forced release on timeout.
module osbm_arb #(
  parameter int NPORT   = 4,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  output logic [NPORT-1:0] ack,
  output logic [1:0]       sel,
  output logic             xbar_en,
  output logic             err_to
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [1:0]       sel_r, sel_s;
  logic [NPORT-1:0] ack_r, ack_s;
  logic             xbar_r, xbar_s;
  logic             err_r, err_s;
  logic [TO_W-1:0]  cnt_r, cnt_s;
  logic [1:0]       win_s;
  logic [1:0]       idx_s;
  logic             found_s;
  logic             tail_own_s;
  logic             to_hit_s;

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      ack_r   <= '0;
      xbar_r  <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      ack_r   <= ack_s;
      xbar_r  <= xbar_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  // Round-robin winner: first requester at or after the pointer
  always_comb begin
    win_s   = ptr_r;
    found_s = 1'b0;
    idx_s   = ptr_r;
    for (int k = 0; k < NPORT; k++) begin
      idx_s = ptr_r + 2'(k);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign tail_own_s = tail[sel_r];
  assign to_hit_s   = TO_EN && (cnt_r == TO_LAST);

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = (|req) ? GRANT : IDLE;
      GRANT:   state_s = tail_own_s ? IDLE : BUSY;
      BUSY:    state_s = (tail_own_s || to_hit_s) ? IDLE : BUSY;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and timeout counter
  always_comb begin
    ack_s  = '0;
    err_s  = 1'b0;
    sel_s  = sel_r;
    ptr_s  = ptr_r;
    cnt_s  = cnt_r;
    xbar_s = xbar_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          ack_s  = {{(NPORT-1){1'b0}}, 1'b1} << win_s;
          sel_s  = win_s;
          xbar_s = 1'b1;
        end else begin
          xbar_s = 1'b0;
        end
      end
      GRANT: begin
        cnt_s = '0;
        if (tail_own_s) begin
          xbar_s = 1'b0;
          ptr_s  = sel_r + 2'd1;
        end else begin
          xbar_s = 1'b1;
        end
      end
      BUSY: begin
        if (tail_own_s || to_hit_s) begin
          // A tail in the same cycle as the timeout wins, so no error is flagged
          xbar_s = 1'b0;
          ptr_s  = sel_r + 2'd1;
          cnt_s  = '0;
          err_s  = !tail_own_s;
        end else if (TO_EN && (cnt_r != {TO_W{1'b1}})) begin
          cnt_s = cnt_r + TO_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        xbar_s = 1'b0;
        cnt_s  = '0;
      end
    endcase
  end

  assign ack     = ack_r;
  assign sel     = sel_r;
  assign xbar_en = xbar_r;
  assign err_to  = err_r;

endmodule

// File: tb/tb_osbm_arb.sv
// Bench for osbm_arb: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a packet-level model of the arbiter.
module tb_osbm_arb;

  localparam int MTO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] tail;
  logic [3:0] ack;
  logic [1:0] sel;
  logic       xbar_en;
  logic       err_to;

  int checks = 0;
  int errors = 0;

  osbm_arb #(.NPORT(4), .TIMEOUT(MTO), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail),
    .ack(ack), .sel(sel), .xbar_en(xbar_en), .err_to(err_to)
  );

  always #5 clk = ~clk;

  // Model: who owns the output, how long the packet has been streaming, and the rotation point
  int         m_owner = -1;
  bit         m_in_grant = 1'b0;
  int         m_busy_cycles = 0;
  int         m_ptr = 0;
  int         m_sel = 0;
  logic [3:0] m_ack = 4'd0;
  bit         m_err = 1'b0;
  bit         m_valid = 1'b0;

  task automatic m_release();
    m_ptr   = (m_owner + 1) % 4;
    m_owner = -1;
  endtask

  always @(posedge clk) begin
    m_ack = 4'd0;
    m_err = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_owner = -1;
      m_in_grant = 1'b0;
      m_busy_cycles = 0;
      m_ptr = 0;
      m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_sel = m_owner;
        m_ack = 4'(1 << m_owner);
        m_in_grant = 1'b1;
      end
    end else if (m_in_grant) begin
      m_in_grant = 1'b0;
      m_busy_cycles = 0;
      if (tail[m_owner]) m_release();
    end else begin
      m_busy_cycles++;
      if (tail[m_owner]) m_release();
      else if (m_busy_cycles == MTO) begin
        m_err = 1'b1;
        m_release();
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_ack", 32'(ack), 32'(m_ack));
      chk("model_xbar_en", 32'(xbar_en), 32'(m_owner >= 0));
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_err_to", 32'(err_to), 32'(m_err));
      chk("ack_onehot0", 32'($countones(ack) <= 1), 32'd1);
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] t, input logic rs);
    req = r; tail = t; rst = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    req = 4'd0; tail = 4'd0; rst = 1'b1;
    @(negedge clk);
    // 1: reset state, then a single requester
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_xbar", 32'(xbar_en), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    cyc(4'b0100, 4'b0000, 1'b0);
    chk("t1_ack", 32'(ack), 32'h4);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_xbar", 32'(xbar_en), 32'h1);
    cyc(4'b0100, 4'b0000, 1'b0);
    chk("t1_ack_off", 32'(ack), 32'h0);
    cyc(4'b0000, 4'b0100, 1'b0);
    chk("t1_release", 32'(xbar_en), 32'h0);
    // 2: all requesting, rotation 0,1,2,3,0
    cyc(4'b0000, 4'b0000, 1'b1);
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 4'b0000, 1'b0);
      chk("t2_order", 32'(ack), 32'(1 << (g % 4)));
      cyc(4'b1111, 4'b0000, 1'b0);
      cyc(4'b1111, 4'(1 << (g % 4)), 1'b0);
      chk("t2_release", 32'(xbar_en), 32'h0);
    end
    // 3: foreign tail ignored, owner's tail releases, pointer moves past owner
    cyc(4'b0010, 4'b0000, 1'b0);
    chk("t3_grant", 32'(ack), 32'h2);
    cyc(4'b0010, 4'b0000, 1'b0);
    cyc(4'b0010, 4'b1000, 1'b0);
    chk("t3_foreign_tail", 32'(xbar_en), 32'h1);
    cyc(4'b0000, 4'b0010, 1'b0);
    chk("t3_release", 32'(xbar_en), 32'h0);
    chk("t3_sel_hold", 32'(sel), 32'h1);
    cyc(4'b1111, 4'b0000, 1'b0);
    chk("t3_ptr", 32'(ack), 32'h4);
    // 4: single-flit packet releases straight from the grant cycle
    cyc(4'b0000, 4'b0100, 1'b0);
    chk("t4_release", 32'(xbar_en), 32'h0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("t4_idle", 32'(xbar_en), 32'h0);
    // 5: timeout after eight tail-less busy cycles
    cyc(4'b1000, 4'b0000, 1'b0);
    chk("t5_grant", 32'(ack), 32'h8);
    cyc(4'b0000, 4'b0000, 1'b0);
    for (int b = 0; b < MTO - 1; b++) begin
      cyc(4'b0000, 4'b0000, 1'b0);
      chk("t5_hold", 32'({xbar_en, err_to}), 32'h2);
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("t5_err", 32'({xbar_en, err_to}), 32'h1);
    cyc(4'b1111, 4'b0000, 1'b0);
    chk("t5_err_pulse", 32'(err_to), 32'h0);
    chk("t5_ptr", 32'(ack), 32'h1);
    // 6: reset in the middle of a packet
    cyc(4'b1111, 4'b0000, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1);
    chk("t6_rst", 32'({ack, sel, xbar_en}), 32'h0);
    cyc(4'b0001, 4'b0000, 1'b0);
    chk("t6_regrant", 32'(ack), 32'h1);
    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
          ($urandom_range(0, 299) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
